// File: rtl/mips_dev_arbiter.sv
// Two-master arbiter for the CPU-side device bridge (DM, TC0, TC1).
// Grants one master per cycle, blanks unmapped writes and returns read data one cycle later.
module mips_dev_arbiter #(
  parameter bit          FIXED_PRIO = 1'b0,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wd,
  input  logic [3:0]  m0_byteen,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rd,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wd,
  input  logic [3:0]  m1_byteen,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rd,
  output logic        m1_err,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wd,
  output logic [3:0]  bus_byteen,
  input  logic [31:0] bus_rd
);

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  logic        last_m1;
  logic [7:0]  starve_cnt;
  logic        any_gnt;
  logic [31:0] sel_addr;
  logic [31:0] sel_wd;
  logic [3:0]  sel_byteen;
  logic        mapped;
  logic [31:0] rd_data;

  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (m0_req && m1_req) begin
      if (FIXED_PRIO) begin
        if (starve_cnt == STARVE_LIM) m1_gnt = 1'b1;
        else                          m0_gnt = 1'b1;
      end else begin
        // last_m1 set means m1 was granted most recently, so m0 takes the tie
        if (last_m1) m0_gnt = 1'b1;
        else         m1_gnt = 1'b1;
      end
    end else begin
      m0_gnt = m0_req;
      m1_gnt = m1_req;
    end
  end

  assign any_gnt    = m0_gnt | m1_gnt;
  assign sel_addr   = m1_gnt ? m1_addr   : m0_addr;
  assign sel_wd     = m1_gnt ? m1_wd     : m0_wd;
  assign sel_byteen = m1_gnt ? m1_byteen : m0_byteen;

  assign mapped = (sel_addr <= 32'h0000_2FFF) ||
                  (sel_addr >= 32'h0000_7F00 && sel_addr <= 32'h0000_7F0B) ||
                  (sel_addr >= 32'h0000_7F10 && sel_addr <= 32'h0000_7F1B);

  // Unmapped accesses keep the address visible but can never write
  assign bus_addr   = any_gnt ? sel_addr : 32'h0;
  assign bus_wd     = (any_gnt && mapped) ? sel_wd     : 32'h0;
  assign bus_byteen = (any_gnt && mapped) ? sel_byteen : 4'h0;
  assign rd_data    = mapped ? bus_rd : 32'h0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_m1    <= 1'b1;
      starve_cnt <= 8'd0;
    end else begin
      if (any_gnt) last_m1 <= m1_gnt;
      if (!FIXED_PRIO || !m1_req || m1_gnt) starve_cnt <= 8'd0;
      else if (starve_cnt != STARVE_LIM)    starve_cnt <= starve_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_err    <= 1'b0;
      m1_err    <= 1'b0;
      m0_rd     <= 32'h0;
      m1_rd     <= 32'h0;
    end else begin
      m0_rvalid <= m0_gnt;
      m1_rvalid <= m1_gnt;
      m0_err    <= m0_gnt & ~mapped;
      m1_err    <= m1_gnt & ~mapped;
      if (m0_gnt) m0_rd <= rd_data;
      if (m1_gnt) m1_rd <= rd_data;
    end
  end

endmodule
